// File: rtl/beep_pkg.sv
// Shared types and helpers for the beep sequencer.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } beep_state_e;

  localparam int unsigned GAP_UNITS = 3;

  // Ceiling log2, never below 1 so degenerate sizes still give a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone source; restart forces the phase high, enable advances it.
module beep_tone_gen
  import beep_pkg::*;
#(
  parameter int unsigned TONE_HALF = 12_500
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic restart,
  output logic tone_c
);

  localparam int unsigned TW = clog2_min1(TONE_HALF);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == TW'(TONE_HALF - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  // Next-cycle phase, so the caller can register it in step with its state.
  assign tone_c = phase_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// Shared buzzer controller: latches requests, grants by fixed priority and
// plays (id+1) gated tone bursts followed by a silent gap.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned UNIT_CYC  = 5_000_000,
  parameter int unsigned TONE_HALF = 12_500
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic [NREQ-1:0]                  req,
  input  logic                             stop,
  input  logic                             mute,
  output logic                             beep,
  output logic                             busy,
  output logic [clog2_min1(NREQ)-1:0]      grant_id,
  output logic                             done
);

  localparam int unsigned GW = clog2_min1(NREQ);
  localparam int unsigned UW = clog2_min1(GAP_UNITS * UNIT_CYC);

  beep_state_e     state_q, state_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [GW-1:0]   beeps_q, beeps_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic            beep_q, beep_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [GW-1:0]   win_id_c;
  logic            win_found_c;
  logic [NREQ-1:0] grant_clr_c;
  logic [UW-1:0]   unit_len_m1_c;
  logic            unit_last_c;
  logic            tone_c;

  // Lowest-index pending requester wins.
  always_comb begin
    win_id_c    = '0;
    win_found_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pending_q[i] && !win_found_c) begin
        win_id_c    = GW'(i);
        win_found_c = 1'b1;
      end
    end
  end

  always_comb begin
    unit_len_m1_c = (state_q == ST_GAP) ? UW'(GAP_UNITS * UNIT_CYC - 1)
                                        : UW'(UNIT_CYC - 1);
    unit_last_c   = (unit_q == unit_len_m1_c);
  end

  // Next-state, pending and output logic.
  always_comb begin
    state_d     = state_q;
    beeps_d     = beeps_q;
    grant_d     = grant_q;
    grant_clr_c = '0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          state_d     = ST_ON;
          grant_d     = win_id_c;
          beeps_d     = win_id_c;
          grant_clr_c = NREQ'(1) << win_id_c;
        end
      end
      ST_ON: begin
        if (unit_last_c) begin
          if (beeps_q != '0) begin
            state_d = ST_OFF;
            beeps_d = beeps_q - GW'(1);
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_OFF: begin
        if (unit_last_c) begin
          state_d = ST_ON;
        end
      end
      ST_GAP: begin
        if (unit_last_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // stop overrides everything, including a grant decided this cycle.
    if (stop) begin
      state_d     = ST_IDLE;
      beeps_d     = beeps_q;
      grant_d     = grant_q;
      grant_clr_c = '0;
      done_d      = 1'b0;
    end

    pending_d = stop ? '0 : ((pending_q & ~grant_clr_c) | req);

    if (state_d != state_q || state_q == ST_IDLE) begin
      unit_d = '0;
    end else begin
      unit_d = unit_q + UW'(1);
    end

    beep_d = (state_d == ST_ON) && !mute && tone_c;
    busy_d = (state_d != ST_IDLE);
  end

  beep_tone_gen #(
    .TONE_HALF (TONE_HALF)
  ) u_tone (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    ((state_q == ST_ON) && (state_d == ST_ON)),
    .restart   ((state_q != ST_ON) && (state_d == ST_ON)),
    .tone_c    (tone_c)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      unit_q    <= '0;
      beeps_q   <= '0;
      grant_q   <= '0;
      pending_q <= '0;
      beep_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      beeps_q   <= beeps_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      beep_q    <= beep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign beep     = beep_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign done     = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with short unit/tone timing.
module tb_beep_sequencer;

  localparam int NREQ = 4;
  localparam int U    = 10;
  localparam int TH   = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] req;
  logic       stop;
  logic       mute;
  logic       beep;
  logic       busy;
  logic [1:0] grant_id;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  beep_sequencer #(
    .NREQ      (NREQ),
    .UNIT_CYC  (U),
    .TONE_HALF (TH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .stop      (stop),
    .mute      (mute),
    .beep      (beep),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  // Pulse a request; returns at the first ON cycle's sample point.
  task automatic start(input logic [3:0] mask);
    req = mask;
    tick();
    req = 4'b0;
    check("pend_busy", 32'(busy), 32'd0);
    tick();
  endtask

  // Walk one pattern from its first ON cycle to its first IDLE cycle.
  task automatic play(input int id, input bit muted, input logic [3:0] side_req,
                      input int stop_k);
    int   on_len;
    int   total;
    logic eb;
    on_len = (2 * id + 1) * U;
    total  = on_len + 3 * U;
    for (int k = 0; k <= total; k++) begin
      eb = !muted && (k < on_len) && ((k / U) % 2 == 0) && (((k % U) / TH) % 2 == 0);
      check($sformatf("p%0d_k%0d_busy", id, k), 32'(busy), 32'(k < total));
      check($sformatf("p%0d_k%0d_beep", id, k), 32'(beep), 32'(eb));
      check($sformatf("p%0d_k%0d_done", id, k), 32'(done), 32'(k == total));
      check($sformatf("p%0d_k%0d_grant", id, k), 32'(grant_id), 32'(id));
      if (k == stop_k) begin
        stop = 1'b1;
        req  = 4'b0001;
        tick();
        stop = 1'b0;
        req  = 4'b0;
        return;
      end
      if (k < total) begin
        req = (side_req != 4'b0 && (k == 5 || k == 20 || k == 40)) ? side_req : 4'b0;
        tick();
        req = 4'b0;
      end
    end
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'd0);
      check($sformatf("%s_c%0d_done", tag, c), 32'(done), 32'd0);
      check($sformatf("%s_c%0d_beep", tag, c), 32'(beep), 32'd0);
      tick();
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req       = 4'b0;
    stop      = 1'b0;
    mute      = 1'b0;
    tick();
    tick();
    check("rst_beep",  32'(beep),     32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_done",  32'(done),     32'd0);
    sys_rst_n = 1'b1;
    tick();
    expect_idle("boot", 3);

    // Single request, pattern 2.
    start(4'b0100);
    play(2, 1'b0, 4'b0, -1);
    tick();
    expect_idle("single", 5);

    // Simultaneous requests: 1 first, 3 after one IDLE cycle.
    start(4'b1010);
    play(1, 1'b0, 4'b0, -1);
    tick();
    play(3, 1'b0, 4'b0, -1);
    tick();
    expect_idle("simul", 5);

    // Three req[0] pulses during pattern 2 coalesce into one playback.
    start(4'b0100);
    play(2, 1'b0, 4'b0001, -1);
    tick();
    play(0, 1'b0, 4'b0, -1);
    tick();
    expect_idle("coal", 40);

    // Stop in IDLE with a fresh pending request.
    req = 4'b0001;
    tick();
    req  = 4'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_idle("stop_idle", 20);

    // Stop during the second ON of pattern 3 with req[1] pending.
    start(4'b1000);
    play(3, 1'b0, 4'b0010, 24);
    check("stop_beep",  32'(beep),     32'd0);
    check("stop_busy",  32'(busy),     32'd0);
    check("stop_done",  32'(done),     32'd0);
    check("stop_grant", 32'(grant_id), 32'd3);
    expect_idle("stop_after", 40);

    // Mute throughout pattern 1: timing unchanged, beep silent.
    mute = 1'b1;
    start(4'b0010);
    play(1, 1'b1, 4'b0, -1);
    mute = 1'b0;
    tick();
    expect_idle("mute", 5);

    // Asynchronous reset mid-ON with another request pending.
    start(4'b0010);
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0;
    tick();
    check("prerst_busy",  32'(busy),     32'd1);
    check("prerst_grant", 32'(grant_id), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("arst_beep",  32'(beep),     32'd0);
    check("arst_busy",  32'(busy),     32'd0);
    check("arst_grant", 32'(grant_id), 32'd0);
    check("arst_done",  32'(done),     32'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    expect_idle("post_rst", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
